alu_unit: RTL and testbench

- 8-bit datapath ALU for the project CPU; sits between the register file read ports and the writeback mux.
- Result, Zero and Parity are combinational from DatA/DatB/Aluop.
- One clock, asynchronous active-low reset.
- A registered shift/carry flag (SCo) captures the carry, borrow or shifted-out bit of arithmetic and shift ops for use by the following instruction.

---
 rtl/alu_unit.sv | 88 ++++++++
 tb/tb_alu_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// 8-bit CPU datapath ALU: combinational result/zero/parity plus a registered shift/carry flag.
// Optional build macro ALU_OUT_REG_EN registers Rslt/Zero/Par so they align with SCo.
module alu_unit #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic [W-1:0] DatA,
  input  logic [W-1:0] DatB,
  input  logic [2:0]   Aluop,
  output logic [W-1:0] Rslt,
  output logic         Zero,
  output logic         Par,
  output logic         SCo
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_LSH = 3'b100;
  localparam logic [2:0] OP_RSH = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  logic [W:0]   sum, diff, shl, shr;
  logic [W-1:0] rslt_c;
  logic         sco_d, sco_q;

  // Shifts run on W+1 bits so the bit pushed out lands in the extra position;
  // amounts beyond W+1 shift everything out and yield zero with no carry.
  assign sum  = {1'b0, DatA} + {1'b0, DatB};
  assign diff = {1'b0, DatA} - {1'b0, DatB};
  assign shl  = {1'b0, DatB} << DatA;
  assign shr  = {DatB, 1'b0} >> DatA;

  always_comb begin
    rslt_c = '0;
    sco_d  = sco_q;
    case (Aluop)
      OP_AND: rslt_c = DatA & DatB;
      OP_ADD: begin rslt_c = sum[W-1:0];  sco_d = sum[W];  end
      OP_SUB: begin rslt_c = diff[W-1:0]; sco_d = diff[W]; end
      OP_OR:  rslt_c = DatA | DatB;
      OP_LSH: begin rslt_c = shl[W-1:0];  sco_d = shl[W];  end
      OP_RSH: begin rslt_c = shr[W:1];    sco_d = shr[0];  end
      OP_CMP: begin
        rslt_c[0] = (DatA != DatB);
        rslt_c[1] = (DatA > DatB);
      end
      OP_XOR: rslt_c = DatA ^ DatB;
      default: rslt_c = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) sco_q <= 1'b0;
    else        sco_q <= sco_d;
  end

  assign SCo = sco_q;

`ifdef ALU_OUT_REG_EN
  logic [W-1:0] rslt_q;
  logic         zero_q, par_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rslt_q <= '0;
      zero_q <= 1'b1;
      par_q  <= 1'b0;
    end else begin
      rslt_q <= rslt_c;
      zero_q <= (rslt_c == '0);
      par_q  <= ^rslt_c;
    end
  end

  assign Rslt = rslt_q;
  assign Zero = zero_q;
  assign Par  = par_q;
`else
  assign Rslt = rslt_c;
  assign Zero = (rslt_c == '0);
  assign Par  = ^rslt_c;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Directed + randomized bench for alu_unit; expected results go through a scoreboard queue.
module tb_alu_unit;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b1;
  logic [7:0] DatA = '0, DatB = '0;
  logic [2:0] Aluop = '0;
  logic [7:0] Rslt;
  logic       Zero, Par, SCo;

  int n_chk = 0;
  int n_fail = 0;
  logic sco_m = 1'b0;

  typedef struct packed {
    logic [7:0] rslt;
    logic       sco;
  } exp_t;
  exp_t sbq[$];

  alu_unit #(.W(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .DatA(DatA), .DatB(DatB), .Aluop(Aluop),
    .Rslt(Rslt), .Zero(Zero), .Par(Par), .SCo(SCo)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] er);
    chk({tag, " rslt"}, Rslt, er);
    chk({tag, " zero"}, {7'b0, Zero}, {7'b0, (er == 8'h00)});
    chk({tag, " par"},  {7'b0, Par},  {7'b0, ^er});
  endtask

  // Drive one op on the falling edge; the flag (and registered outputs) are checked after the rising edge.
  task automatic step(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic es);
    exp_t e;
    @(negedge Clk);
    Aluop = op; DatA = a; DatB = b;
    sbq.push_back('{rslt: er, sco: es});
    sco_m = es;
`ifndef ALU_OUT_REG_EN
    #1 chk_out(tag, er);
`endif
    @(posedge Clk);
    #1 e = sbq.pop_front();
    chk({tag, " sco"}, {7'b0, SCo}, {7'b0, e.sco});
`ifdef ALU_OUT_REG_EN
    chk_out(tag, e.rslt);
`endif
  endtask

  // Reference model: shifts done one bit at a time; returns {update, sco, rslt}.
  function automatic logic [9:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] v;
    logic [7:0] r;
    logic upd, c;
    upd = 1'b0; c = 1'b0; r = '0;
    case (op)
      3'd0: r = a & b;
      3'd1: begin v = 9'(a) + 9'(b); r = v[7:0]; c = v[8]; upd = 1'b1; end
      3'd2: begin r = a - b; c = (a < b); upd = 1'b1; end
      3'd3: r = a | b;
      3'd4: begin
        v = {1'b0, b};
        for (int i = 0; i < int'(a); i++) v = {v[7:0], 1'b0};
        r = v[7:0]; c = v[8]; upd = 1'b1;
      end
      3'd5: begin
        v = {b, 1'b0};
        for (int i = 0; i < int'(a); i++) v = {1'b0, v[8:1]};
        r = v[8:1]; c = v[0]; upd = 1'b1;
      end
      3'd6: r = {6'b0, (a > b), (a != b)};
      default: r = a ^ b;
    endcase
    return {upd, c, r};
  endfunction

  initial begin
    logic [9:0] m;
    logic [2:0] op;
    logic [7:0] a, b;

    #1 Rst_n = 1'b0;
    #2 chk("reset sco", {7'b0, SCo}, 8'h00);
    @(negedge Clk); Rst_n = 1'b1;

    step("add 200+100", 3'd1, 8'd200, 8'd100, 8'd44, 1'b1);
    // Async reset with flag set, then held across an edge with a carrying op pending
    #2 Rst_n = 1'b0;
    #1 chk("async rst sco", {7'b0, SCo}, 8'h00);
    @(posedge Clk); #1 chk("rst over pend", {7'b0, SCo}, 8'h00);
    @(negedge Clk); Rst_n = 1'b1;
    step("add after rst",  3'd1, 8'd200, 8'd100, 8'd44, 1'b1);

    step("add 1+1",   3'd1, 8'd1, 8'd1, 8'd2, 1'b0);
    step("and 4&1",   3'd0, 8'd4, 8'd1, 8'd0, 1'b0);
    step("or 4|1",    3'd3, 8'd4, 8'd1, 8'd5, 1'b0);
    step("sub 4-1",   3'd2, 8'd4, 8'd1, 8'd3, 1'b0);
    step("sub 1-4",   3'd2, 8'd1, 8'd4, 8'd253, 1'b1);
    step("sub 7-7",   3'd2, 8'd7, 8'd7, 8'd0, 1'b0);
    step("lsh 3,12",  3'd4, 8'd3, 8'd12, 8'd96, 1'b0);
    step("lsh 1,80",  3'd4, 8'd1, 8'h80, 8'd0, 1'b1);
    step("lsh 9,ff",  3'd4, 8'd9, 8'hFF, 8'd0, 1'b0);
    step("lsh 8,01",  3'd4, 8'd8, 8'h01, 8'd0, 1'b1);
    step("lsh 0,5a",  3'd4, 8'd0, 8'h5A, 8'h5A, 1'b0);
    step("rsh 2,8",   3'd5, 8'd2, 8'd8, 8'd2, 1'b0);
    step("rsh 1,3",   3'd5, 8'd1, 8'd3, 8'd1, 1'b1);
    step("and hold",  3'd0, 8'hFF, 8'h0F, 8'h0F, 1'b1);
    step("rsh 8,80",  3'd5, 8'd8, 8'h80, 8'd0, 1'b1);
    step("rsh 9,ff",  3'd5, 8'd9, 8'hFF, 8'd0, 1'b0);
    step("rsh 0,33",  3'd5, 8'd0, 8'h33, 8'h33, 1'b0);
    step("add ff+1",  3'd1, 8'hFF, 8'h01, 8'h00, 1'b1);
    step("cmp 4,1",   3'd6, 8'd4, 8'd1, 8'b11, 1'b1);
    step("cmp 4,4",   3'd6, 8'd4, 8'd4, 8'd0, 1'b1);
    step("cmp 1,4",   3'd6, 8'd1, 8'd4, 8'b01, 1'b1);
    step("xor f0^ff", 3'd7, 8'hF0, 8'hFF, 8'h0F, 1'b1);
    step("or hold",   3'd3, 8'h00, 8'h00, 8'h00, 1'b1);
    step("add 0+0",   3'd1, 8'd0, 8'd0, 8'd0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = (op == 3'd4 || op == 3'd5) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      b  = 8'($urandom);
      m  = model(op, a, b);
      step($sformatf("rand%0d op%0d", i, op), op, a, b, m[7:0], m[9] ? m[8] : sco_m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
